// File: rtl/probe_pkg.sv
// Shared constants and types for the probe display stage: view codes,
// the active-low hex font and the per-scan snapshot record.
package probe_pkg;

  typedef enum logic [1:0] {
    VIEW_PC  = 2'd0,
    VIEW_ALU = 2'd1,
    VIEW_WB  = 2'd2,
    VIEW_RAM = 2'd3
  } view_e;

  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // {dp,g,f,e,d,c,b,a}, active-low, dp off; entry 0 is the rightmost byte
  localparam logic [15:0][7:0] HEX_FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // View is captured with the value so blanking can never mix two views in one scan
  typedef struct packed {
    view_e       view;
    logic [31:0] val;
  } snap_t;

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to seven active-low segments {g,f,e,d,c,b,a}.
module hex7seg
  import probe_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_FONT[nib][6:0];

endmodule

// File: rtl/probe_display.sv
// Debug view of CPU observation buses on an 8-digit multiplexed seven-segment
// display; a debounced button selects the view, the value is frozen per scan.
module probe_display
  import probe_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] r3_din,
  input  logic        r3_wr,
  input  logic [31:0] spo,
  input  logic        btn_sel,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [1:0]  view
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int IW = $clog2(NUM_DIGITS);

  logic          btn_s1, btn_s2, btn_acc, btn_acc_d;
  logic [DW-1:0] db_cnt;
  view_e         view_q;
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [31:0]   cap;
  logic          written;
  snap_t         snap;
  logic [31:0]   sel_val;
  logic [7:0]    an_q, seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_d;
  logic          scan_tick, scan_wrap, press;

  assign scan_tick = (pre == PW'(SCAN_DIV - 1));
  assign scan_wrap = scan_tick && (idx == IW'(NUM_DIGITS - 1));
  assign press     = btn_acc & ~btn_acc_d;

  // Button: two-flop synchroniser, then accept only after a stable run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      btn_acc   <= 1'b0;
      btn_acc_d <= 1'b0;
      db_cnt    <= '0;
    end else begin
      btn_s1    <= btn_sel;
      btn_s2    <= btn_s1;
      btn_acc_d <= btn_acc;
      if (btn_s2 == btn_acc) begin
        db_cnt <= '0;
      end else if (db_cnt == DW'(DEBOUNCE - 1)) begin
        btn_acc <= btn_s2;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      view_q <= VIEW_PC;
    end else if (press) begin
      view_q <= view_e'(view_q + 2'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap     <= '0;
      written <= 1'b0;
    end else begin
      if (r3_wr) cap <= r3_din;
      written <= written | r3_wr;
    end
  end

  always_comb begin
    sel_val = '0;
    case (view_q)
      VIEW_PC:  sel_val = {24'h0, pc};
      VIEW_ALU: sel_val = alu_out;
      VIEW_WB:  sel_val = cap;
      VIEW_RAM: sel_val = spo;
      default:  sel_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      idx  <= '0;
      snap <= '0;
    end else begin
      if (scan_tick) begin
        pre <= '0;
        idx <= idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      if (scan_wrap) snap <= '{view: view_q, val: sel_val};
    end
  end

  logic [NUM_DIGITS-1:0][6:0] digit_seg;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    hex7seg u_hex (
      .nib (snap.val[4*d +: 4]),
      .seg (digit_seg[d])
    );
  end

  always_comb begin
    an_d  = ~(NUM_DIGITS'(1) << idx);
    seg_d = {1'b1, digit_seg[idx]};
    if (snap.view == VIEW_PC && idx >= IW'(2)) seg_d = SEG_BLANK;
    if (idx == '0 && written) seg_d[7] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 8'hFF;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign view = view_q;

endmodule

// File: tb/tb_probe_display.sv
// Scoreboard bench for probe_display: stimulus queues expected digit drives and
// view changes, monitors pop and compare as the display presents them.
module tb_probe_display;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 8;

  logic        clk, rst_n, r3_wr, btn_sel;
  logic [7:0]  pc, an, seg;
  logic [31:0] alu_out, r3_din, spo;
  logic [1:0]  view;

  probe_display #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pc      (pc),
    .alu_out (alu_out),
    .r3_din  (r3_din),
    .r3_wr   (r3_wr),
    .spo     (spo),
    .btn_sel (btn_sel),
    .an      (an),
    .seg     (seg),
    .view    (view)
  );

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
  } dexp_t;

  typedef struct {
    logic [1:0] v;
    int         cyc;
  } vexp_t;

  dexp_t dq[$];
  vexp_t vq[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  bit    armed = 0;
  bit    active = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout (cycle %0d)", name, cyc);
  endtask

  // segs packs digit 7..0 as {d7,...,d0}
  task automatic push_scan(input logic [63:0] segs);
    for (int d = 0; d < 8; d++) begin
      dexp_t e;
      e.an  = ~(8'h01 << d);
      e.seg = segs[8*d +: 8];
      dq.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while ((dq.size() != 0 || armed) && n < max) begin
      @(posedge clk);
      n++;
    end
    if (n >= max) begin
      timeout(name);
      dq.delete();
      armed = 0;
    end
  endtask

  task automatic wait_active(input string name, input int max);
    int n = 0;
    while (!active && n < max) begin
      @(posedge clk);
      n++;
    end
    if (n >= max) timeout(name);
  endtask

  task automatic wait_an(input string name, input logic [7:0] target, input int max);
    int n = 0;
    @(posedge clk);
    #1;
    while (an !== target && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= max) timeout(name);
  endtask

  // Accepted press: view expected 2 sync + DEBOUNCE + 1 edges after the drive
  task automatic press(input logic [1:0] nv);
    int n = 0;
    vexp_t e;
    @(posedge clk);
    #1;
    btn_sel = 1'b1;
    e.v = nv;
    e.cyc = cyc + 2 + DEBOUNCE + 1;
    vq.push_back(e);
    repeat (20) @(posedge clk);
    #1;
    btn_sel = 1'b0;
    repeat (30) @(posedge clk);
    while (vq.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (n >= 50) begin
      timeout("view_change");
      vq.delete();
    end
  endtask

  // Display monitor: a new an value is one digit presentation
  initial begin
    logic [7:0] prev_an;
    logic [1:0] prev_view;
    int         last_cyc;
    bit         first;
    dexp_t      e;
    vexp_t      ve;
    prev_an = 8'hFF;
    prev_view = 2'd0;
    last_cyc = 0;
    first = 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0;
      end else begin
        if (an !== prev_an) begin
          if (!active && armed && an === 8'hFE) begin
            active = 1;
            armed = 0;
            first = 1;
          end
          if (active) begin
            e = dq.pop_front();
            chk("digit_an", {24'h0, an}, {24'h0, e.an});
            chk("digit_seg", {24'h0, seg}, {24'h0, e.seg});
            if (!first) chk("digit_period", cyc - last_cyc, SCAN_DIV);
            first = 0;
            last_cyc = cyc;
            if (dq.size() == 0) active = 0;
          end
        end
        if (view !== prev_view) begin
          if (vq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL view_unexpected actual=%0d was=%0d (cycle %0d)", view, prev_view, cyc);
          end else begin
            ve = vq.pop_front();
            chk("view_value", {30'h0, view}, {30'h0, ve.v});
            chk("view_cycle", cyc, ve.cyc);
          end
        end
      end
      prev_an = an;
      prev_view = view;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    btn_sel = 1'b0;
    pc = 8'h3A;
    alu_out = 32'h11111111;
    r3_din = 32'h0;
    r3_wr = 1'b0;
    spo = 32'h12345678;
    #12;
    chk("reset_an", {24'h0, an}, 32'hFF);
    chk("reset_seg", {24'h0, seg}, 32'hFF);
    chk("reset_view", {30'h0, view}, 32'h0);

    // Scan 1 shows the cleared snapshot, scan 2 shows pc=3A
    push_scan(64'hFFFF_FFFF_FFFF_C0C0);
    push_scan(64'hFFFF_FFFF_FFFF_B088);
    armed = 1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain("scan_pc", 120);

    // Short glitch must be ignored, then an accepted press to view 1
    @(posedge clk);
    #1;
    btn_sel = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    btn_sel = 1'b0;
    repeat (5) @(posedge clk);
    press(2'd1);

    // alu_out changes while digit 3 is lit: this scan stays 1, next is 2
    repeat (10) @(posedge clk);
    push_scan(64'hF9F9_F9F9_F9F9_F9F9);
    push_scan(64'hA4A4_A4A4_A4A4_A4A4);
    armed = 1;
    wait_active("scan_alu_start", 80);
    wait_an("digit3", 8'hF7, 40);
    alu_out = 32'h22222222;
    wait_drain("scan_alu", 120);

    // Write-back capture, dp lit on digit 0
    press(2'd2);
    @(posedge clk);
    #1;
    r3_din = 32'hDEADBEEF;
    r3_wr = 1'b1;
    @(posedge clk);
    #1;
    r3_wr = 1'b0;
    r3_din = 32'h0;
    repeat (40) @(posedge clk);
    push_scan(64'hA186_88A1_8386_860E);
    armed = 1;
    wait_drain("scan_wb", 120);

    // Reset while digit 5 is lit and the written flag is set
    wait_an("digit5", 8'hDF, 80);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_an", {24'h0, an}, 32'hFF);
    chk("midreset_seg", {24'h0, seg}, 32'hFF);
    chk("midreset_view", {30'h0, view}, 32'h0);
    push_scan(64'hFFFF_FFFF_FFFF_C0C0);
    armed = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_drain("scan_after_reset", 80);

    // Four presses walk the views and wrap back to 0
    press(2'd1);
    press(2'd2);
    press(2'd3);
    press(2'd0);
    repeat (40) @(posedge clk);
    push_scan(64'hFFFF_FFFF_FFFF_B088);
    armed = 1;
    wait_drain("scan_wrapped", 120);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
